// File: rtl/bloco_defuzzificador.sv
// Interval type-2 output stage: Nie-Tan type reduction plus centroid defuzzification.
// A serial 3-term multiply-accumulate feeds an 8-step restoring divider; fixed 12-cycle latency.
module bloco_defuzzificador #(
  parameter logic [7:0] C1      = 8'd32,
  parameter logic [7:0] C2      = 8'd128,
  parameter logic [7:0] C3      = 8'd223,
  parameter logic [7:0] DEFAULT = 8'd128
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       EN_SCLK,
  input  logic       start,
  input  logic [7:0] f1_UP,
  input  logic [7:0] f1_LOW,
  input  logic [7:0] f2_UP,
  input  logic [7:0] f2_LOW,
  input  logic [7:0] f3_UP,
  input  logic [7:0] f3_LOW,
  output logic       busy,
  output logic       done,
  output logic       erro_zero,
  output logic [7:0] saida_crisp
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic [2:0][7:0] r_low;
  logic [2:0][7:0] r_up;
  logic [18:0]     r_num;
  logic [10:0]     r_den;
  logic [10:0]     r_rem;
  logic [7:0]      r_quo;
  logic [2:0]      r_cnt;

  logic [7:0]  w_low;
  logic [7:0]  w_up;
  logic [7:0]  w_c;
  logic [8:0]  w_sum;
  logic [16:0] w_prod;
  logic [10:0] w_rem_cur;
  logic [11:0] w_trial;
  logic        w_ge;
  logic [10:0] w_diff;

  // r_cnt is the term index during ACC and the quotient bit index during DIV
  always_comb begin
    w_low = '0;
    w_up  = '0;
    w_c   = '0;
    case (r_cnt)
      3'd0:    begin w_low = r_low[0]; w_up = r_up[0]; w_c = C1; end
      3'd1:    begin w_low = r_low[1]; w_up = r_up[1]; w_c = C2; end
      3'd2:    begin w_low = r_low[2]; w_up = r_up[2]; w_c = C3; end
      default: begin w_low = '0; w_up = '0; w_c = '0; end
    endcase
  end

  assign w_sum  = {1'b0, w_low} + {1'b0, w_up};
  assign w_prod = {9'd0, w_c} * {8'd0, w_sum};

  // First DIV step seeds the remainder from the top of num; it is already below den.
  assign w_rem_cur = (r_cnt == 3'd7) ? r_num[18:8] : r_rem;
  assign w_trial   = {w_rem_cur, r_num[r_cnt]};
  assign w_ge      = (w_trial >= {1'b0, r_den});
  // True difference is below den, so the 11-bit wrap is exact
  assign w_diff    = w_trial[10:0] - r_den;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_low       <= '0;
      r_up        <= '0;
      r_num       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      erro_zero   <= 1'b0;
      saida_crisp <= 8'd0;
    end else if (EN_SCLK) begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_low   <= {f3_LOW, f2_LOW, f1_LOW};
            r_up    <= {f3_UP, f2_UP, f1_UP};
            r_num   <= '0;
            r_den   <= '0;
            r_cnt   <= 3'd0;
            busy    <= 1'b1;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          r_den <= r_den + {2'b00, w_sum};
          r_num <= r_num + {2'b00, w_prod};
          if (r_cnt == 3'd2) begin
            r_cnt   <= 3'd7;
            r_state <= S_DIV;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DIV: begin
          // Zero denominator still spends the full 8 cycles to keep latency fixed
          if (r_den != 11'd0) begin
            r_rem <= w_ge ? w_diff : w_trial[10:0];
            r_quo <= {r_quo[6:0], w_ge};
          end
          if (r_cnt == 3'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        S_DONE: begin
          saida_crisp <= (r_den == 11'd0) ? DEFAULT : r_quo;
          erro_zero   <= (r_den == 11'd0);
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bloco_defuzzificador.sv
// Directed bench for bloco_defuzzificador: expected crisp results are queued at start
// and compared when done pulses, alongside latency, handshake and reset behaviour.
module tb_bloco_defuzzificador;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       EN_SCLK = 1'b0;
  logic       start = 1'b0;
  logic [7:0] f1_UP = '0, f1_LOW = '0, f2_UP = '0, f2_LOW = '0, f3_UP = '0, f3_LOW = '0;
  logic       busy, done, erro_zero;
  logic [7:0] saida_crisp;

  int         n_assert = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];

  bloco_defuzzificador dut (
    .clk(clk), .RESET(RESET), .EN_SCLK(EN_SCLK), .start(start),
    .f1_UP(f1_UP), .f1_LOW(f1_LOW), .f2_UP(f2_UP), .f2_LOW(f2_LOW),
    .f3_UP(f3_UP), .f3_LOW(f3_LOW),
    .busy(busy), .done(done), .erro_zero(erro_zero), .saida_crisp(saida_crisp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_f(input logic [7:0] l1, u1, l2, u2, l3, u3);
    f1_LOW = l1; f1_UP = u1; f2_LOW = l2; f2_UP = u2; f3_LOW = l3; f3_UP = u3;
  endtask

  // Reference: {erro_zero, saida_crisp} from plain integer arithmetic
  function automatic logic [8:0] model(input logic [7:0] l1, u1, l2, u2, l3, u3);
    int den, num;
    den = int'(l1) + int'(u1) + int'(l2) + int'(u2) + int'(l3) + int'(u3);
    num = 32 * (int'(l1) + int'(u1)) + 128 * (int'(l2) + int'(u2)) + 223 * (int'(l3) + int'(u3));
    if (den == 0) return {1'b1, 8'd128};
    return {1'b0, 8'(num / den)};
  endfunction

  task automatic run_op(input logic [7:0] l1, u1, l2, u2, l3, u3,
                        input bit toggle_en, input bit repulse, input bit change_in);
    int         edges;
    int         cyc;
    int         dones;
    bit         en_was;
    bit         busy_bad;
    logic [8:0] e;
    @(negedge clk);
    set_f(l1, u1, l2, u2, l3, u3);
    start   = 1'b1;
    EN_SCLK = 1'b1;
    exp_q.push_back(model(l1, u1, l2, u2, l3, u3));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    if (change_in) set_f(~l1, ~u1, ~l2, ~u2, ~l3, ~u3);
    edges = 0; cyc = 0; busy_bad = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (toggle_en) EN_SCLK = ~EN_SCLK;
      else           EN_SCLK = 1'b1;
      start  = repulse && (edges >= 2) && (edges <= 5);
      en_was = EN_SCLK;
      @(negedge clk);
      cyc++;
      if (en_was) edges++;
      if (done !== 1'b1 && busy !== 1'b1) busy_bad = 1;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency_edges", edges, 12);
    check("busy_at_done", busy, 0);
    check("busy_held", busy_bad, 0);
    e = exp_q.pop_front();
    check("saida_crisp", saida_crisp, e[7:0]);
    check("erro_zero", erro_zero, e[8]);
    EN_SCLK = 1'b0;
    @(negedge clk);
    check("done_hold_en0", done, 1);
    EN_SCLK = 1'b1;
    @(negedge clk);
    check("done_clear", done, 0);
    check("saida_hold", saida_crisp, e[7:0]);
    $display("op l1=%0d u1=%0d l2=%0d u2=%0d l3=%0d u3=%0d -> saida=%0d erro=%0d edges=%0d",
             l1, u1, l2, u2, l3, u3, saida_crisp, erro_zero, edges);
    if (repulse) begin
      dones = 0;
      repeat (20) begin
        @(negedge clk);
        if (done === 1'b1) dones++;
      end
      check("no_extra_done", dones, 0);
      check("idle_after_repulse", busy, 0);
    end
  endtask

  initial begin
    int dones;
    EN_SCLK = 1'b1;
    RESET   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro_zero, 0);
    check("rst_saida", saida_crisp, 0);
    RESET = 1'b1;
    @(negedge clk);

    run_op(8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);          // 32
    check("single_set_value", saida_crisp, 32);
    run_op(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 0, 0, 0);  // 127
    check("equal_firing_value", saida_crisp, 127);
    run_op(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 0, 0, 0);        // 191
    check("mixed_value", saida_crisp, 191);
    run_op(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0);              // 128, erro
    check("zero_flag", erro_zero, 1);
    run_op(8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 1, 0, 0);          // toggled enable
    check("erro_cleared", erro_zero, 0);
    run_op(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 0, 1, 0);  // start re-pulsed
    run_op(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 0, 0, 1);        // inputs change after capture

    // Abort during the divide phase
    @(negedge clk);
    set_f(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
    start   = 1'b1;
    EN_SCLK = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_abort", busy, 1);
    #2 RESET = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_saida", saida_crisp, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    RESET = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    $display("abort: busy=%0d saida=%0d dones=%0d", busy, saida_crisp, dones);

    run_op(8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 0, 0, 0);
    check("after_abort_value", saida_crisp, 191);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
